// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: default byte width, frame size
// and the scheduler state encoding.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned FRAME_WIDTH     = UART_DATA_WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, with wrap.
// The pointer register is owned by the caller.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] idx;

  // Scan farthest-first so the nearest candidate after ptr is the last write.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    any_req   = |req;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        grant          = '0;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between NUM_REQ byte producers: round-robin grant, one
// transmit pulse per frame, busy tracking with a start timeout.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ       = 4,
  parameter  int unsigned DATA_WIDTH    = UART_DATA_WIDTH,
  parameter  int unsigned START_TIMEOUT = 16,
  localparam int unsigned IDX_W         = $clog2(NUM_REQ),
  localparam int unsigned CNT_W         = $clog2(START_TIMEOUT + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_transmit,
  input  logic                          tx_busy,
  output logic [IDX_W-1:0]              owner,
  output logic                          active,
  output logic                          start_err
);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic                  xmit_q, xmit_d;
  logic                  active_q, active_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      owner_q  <= '0;
      data_q   <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      xmit_q   <= 1'b0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      xmit_q   <= xmit_d;
      active_q <= active_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    data_d   = data_q;
    ack_d    = '0;
    done_d   = '0;
    xmit_d   = 1'b0;
    active_d = active_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d    = grant_idx;
          owner_d  = grant_idx;
          ack_d    = grant;
          xmit_d   = 1'b1;
          active_d = 1'b1;
          state_d  = ISSUE;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) data_d = req_data[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          // Pointer is left on the failed requester so it drops to lowest priority.
          err_d    = 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            done_d[i] = (owner_q == IDX_W'(i));
          end
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ack     = ack_q;
  assign req_done    = done_q;
  assign tx_data     = data_q;
  assign tx_transmit = xmit_q;
  assign owner       = owner_q;
  assign active      = active_q;
  assign start_err   = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural uart_tx busy stub
// and a round-robin reference model over the requests the bench itself drives.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 8;
  localparam int TO        = 16;
  localparam int BIT_CYC   = 2;
  localparam int FRAME_CYC = FRAME_WIDTH * BIT_CYC;
  localparam int M_MANUAL  = 0;
  localparam int M_HOLD    = 1;
  localparam int M_RANDOM  = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*DW-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    req_ack, req_done;
  logic [DW-1:0]         tx_data;
  logic                  tx_transmit, tx_busy, active, start_err;
  logic [1:0]            owner;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .START_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_ack(req_ack), .req_done(req_done), .tx_data(tx_data),
    .tx_transmit(tx_transmit), .tx_busy(tx_busy), .owner(owner),
    .active(active), .start_err(start_err)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy rises one cycle after transmit and lasts one frame.
  logic stub_en = 1'b1;
  int   sc;
  always @(posedge clk or posedge reset) begin
    if (reset) sc <= 0;
    else if (tx_transmit && stub_en) sc <= FRAME_CYC + 1;
    else if (sc > 0) sc <= sc - 1;
  end
  assign tx_busy = stub_en && (sc > 0) && (sc <= FRAME_CYC);

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Request vector as seen by the DUT at each rising edge.
  logic [NUM_REQ-1:0]    snap_req;
  logic [NUM_REQ*DW-1:0] snap_data;
  int                    cyc = 0;
  always @(posedge clk) begin
    snap_req  <= req;
    snap_data <= req_data;
    cyc++;
  end

  // Reference model and monitor.
  int      mptr = NUM_REQ - 1;
  int      exp_done[$];
  int      grants[$];
  bit      in_frame = 0;
  bit      prev_idle = 0;
  logic [DW-1:0] frame_data = '0;
  int      ack_cyc = 0;
  int      done_total = 0, err_total = 0, xmit_total = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_frame  = 0;
      prev_idle = 0;
      mptr      = NUM_REQ - 1;
      exp_done.delete();
    end else begin
      if (prev_idle && snap_req != '0) check("grant_latency", (req_ack != '0), 1);
      if (req_ack != '0 || tx_transmit) begin
        int w;
        logic [DW-1:0] ed;
        w  = -1;
        ed = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          int idx;
          idx = (mptr + k) % NUM_REQ;
          if (w < 0 && snap_req[idx]) w = idx;
        end
        if (tx_transmit) xmit_total++;
        check("grant_while_idle", in_frame, 0);
        check("xmit_not_busy", tx_busy, 0);
        check("xmit_pulse", tx_transmit, 1);
        check("ack_onehot", req_ack, (w < 0) ? 0 : (1 << w));
        if (w >= 0) begin
          ed = snap_data[w*DW +: DW];
          check("tx_data_grant", tx_data, ed);
          check("owner", owner, w);
          mptr       = w;
          frame_data = ed;
          ack_cyc    = cyc;
          in_frame   = 1;
          exp_done.push_back(w);
          grants.push_back(w);
        end
      end
      if (req_done != '0) begin
        done_total++;
        check("done_expected", exp_done.size(), 1);
        check("done_not_err", start_err, 0);
        if (exp_done.size() > 0) begin
          int w;
          w = exp_done.pop_front();
          check("done_index", req_done, 1 << w);
        end
        in_frame = 0;
      end
      if (start_err) begin
        err_total++;
        check("err_expected", stub_en, 0);
        check("err_latency", cyc - ack_cyc, TO + 1);
        if (exp_done.size() > 0) void'(exp_done.pop_front());
        in_frame = 0;
      end
      if (in_frame) check("tx_data_hold", tx_data, frame_data);
      check("active", active, in_frame);
      prev_idle = !in_frame;
    end
  end

  // Requester behaviour after ack, plus random traffic.
  int mode = M_MANUAL;
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ack[i]) begin
          if (mode == M_MANUAL) req[i] = 1'b0;
          else if (mode == M_RANDOM) begin
            req[i] = 1'($urandom_range(0, 1));
            req_data[i*DW +: DW] = DW'($urandom);
          end
        end else if (mode == M_RANDOM) begin
          if (!req[i] && $urandom_range(0, 7) == 0) begin
            req[i] = 1'b1;
            req_data[i*DW +: DW] = DW'($urandom);
          end else if (req[i] && $urandom_range(0, 31) == 0) begin
            req[i] = 1'b0;
          end else if (req[i] && $urandom_range(0, 7) == 0) begin
            req_data[i*DW +: DW] = DW'($urandom);
          end
        end
      end
    end
  end

  task automatic wait_for(input int sel, input int target, input int max_cyc, input string name);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    while (!ok && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
      case (sel)
        0:       ok = (grants.size() >= target);
        1:       ok = (done_total >= target);
        2:       ok = (err_total >= target);
        3:       ok = tx_busy;
        default: ok = (!in_frame && exp_done.size() == 0);
      endcase
    end
    check(name, ok, 1);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("reset_outputs_zero",
          {req_ack, req_done, tx_data, tx_transmit, owner, active, start_err}, '0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    grants.delete();
  endtask

  initial begin
    int base, n, got;
    logic [DW-1:0] last;

    // Power-on reset.
    #1 reset = 1'b1;
    #1 check("por_outputs_zero",
             {req_ack, req_done, tx_data, tx_transmit, owner, active, start_err}, '0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single request from requester 2.
    #1;
    req_data[2*DW +: DW] = 8'hA5;
    req[2] = 1'b1;
    wait_for(0, 1, 10, "single_grant");
    check("single_grant_idx", grants[0], 2);
    wait_for(1, 1, 200, "single_done");
    check("single_data_held", tx_data, 8'hA5);

    // Round-robin with everything pending.
    do_reset();
    mode = M_HOLD;
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    req = '1;
    base = done_total;
    n = xmit_total;
    wait_for(1, base + 5, 600, "rr_five_frames");
    req = '0;
    mode = M_MANUAL;
    repeat (5) @(negedge clk);
    check("rr_xmit_count", xmit_total - n, 5);
    for (int i = 0; i < 5; i++) check("rr_order", grants[i], i % NUM_REQ);

    // Contention: 1 arrives while 0 is on the line and 0 stays pending.
    do_reset();
    mode = M_HOLD;
    req_data[0 +: DW] = 8'h55;
    req[0] = 1'b1;
    wait_for(0, 1, 10, "cont_first");
    repeat (5) @(negedge clk);
    #1;
    req_data[1*DW +: DW] = 8'h66;
    req[1] = 1'b1;
    wait_for(0, 3, 300, "cont_three");
    req = '0;
    mode = M_MANUAL;
    check("cont_second_owner", grants[1], 1);
    check("cont_third_owner", grants[2], 0);
    wait_for(4, 0, 200, "cont_drain");

    // Start timeout with a silent transmitter.
    do_reset();
    stub_en = 1'b0;
    req_data[3*DW +: DW] = 8'h77;
    req[3] = 1'b1;
    base = done_total;
    wait_for(2, err_total + 1, 60, "timeout_err");
    check("timeout_no_done", done_total - base, 0);
    stub_en = 1'b1;
    req_data[0 +: DW] = 8'h01;
    req_data[3*DW +: DW] = 8'h03;
    req = 4'b1001;
    n = grants.size();
    wait_for(0, n + 1, 10, "post_timeout_grant");
    check("post_timeout_owner", grants[n], 0);
    wait_for(1, done_total + 2, 300, "post_timeout_done");

    // Reset while a frame is in flight.
    req_data[0 +: DW] = 8'h5A;
    req[0] = 1'b1;
    wait_for(3, 0, 20, "midframe_busy");
    repeat (3) @(negedge clk);
    #1;
    req_data[1*DW +: DW] = 8'h99;
    req[1] = 1'b1;
    base = done_total;
    #2 reset = 1'b1;
    #1 check("midframe_reset_zero",
             {req_ack, req_done, tx_data, tx_transmit, owner, active, start_err}, '0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    grants.delete();
    got = 0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (got == 0 && req_ack[1]) got = i;
    end
    check("midframe_regrant_within_2", (got >= 1 && got <= 2), 1);
    check("midframe_no_done", done_total - base, 0);
    wait_for(4, 0, 200, "midframe_drain");

    // Withdrawn request never sampled at an edge.
    last = frame_data;
    n = xmit_total;
    @(negedge clk); #1;
    req_data[2*DW +: DW] = 8'hEE;
    req[2] = 1'b1;
    #2 req[2] = 1'b0;
    repeat (6) @(negedge clk);
    check("withdraw_no_xmit", xmit_total - n, 0);
    check("withdraw_tx_data", tx_data, last);

    // Random traffic.
    n = grants.size();
    mode = M_RANDOM;
    repeat (3000) @(negedge clk);
    #1;
    mode = M_MANUAL;
    req = '0;
    wait_for(4, 0, 200, "random_drain");
    check("random_activity", (grants.size() - n >= 20), 1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one uart_tx transmitter between NUM_REQ independent byte producers. Each producer has a request/ack/done channel. A round-robin arbiter picks one pending request and latches its byte. The block then drives uart_tx's TxData/transmit pair and tracks busy until the frame (start, data, parity, stop) completes. It sits between the command/status logic and the uart_tx instance, and is the only driver of TxData and transmit.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width; must match the uart_tx DATA_WIDTH
START_TIMEOUT, 16, max cycles to wait for tx_busy to rise after a transmit pulse

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester "byte pending", level, held until ack
req_data  input  NUM_REQ*DATA_WIDTH  byte for requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ack  output  NUM_REQ  one-cycle pulse: byte latched; requester may change req/req_data next cycle
req_done  output  NUM_REQ  one-cycle pulse: that requester's frame finished on the line
tx_data  output  DATA_WIDTH  to uart_tx TxData; registered, stable for the whole frame
tx_transmit  output  1  to uart_tx transmit; single-cycle pulse
tx_busy  input  1  from uart_tx busy
owner  output  $clog2(NUM_REQ)  index of the current/last granted requester
active  output  1  high from grant until req_done or timeout
start_err  output  1  one-cycle pulse: tx_busy never rose within START_TIMEOUT

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; rr pointer=NUM_REQ-1, so requester 0 has first priority; timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE.
- IDLE:
  - If any req bit is high, pick the first set bit searching from pointer+1 upward, with modular wrap.
  - Same clock edge: latch the winner's req_data into tx_data, set owner, pointer=winner, req_ack[winner]=1, tx_transmit=1, active=1.
  - Go to ISSUE.
  - Latency: req sampled high at edge k gives ack and transmit visible after edge k.
- ISSUE: lasts one cycle. tx_transmit and req_ack return to 0. Clear the counter. Go to WAIT_START.
- WAIT_START:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter. At count==START_TIMEOUT-1: pulse start_err, clear active, go to IDLE.
  - No req_done on timeout. The pointer stays advanced, so the failed requester loses priority.
- WAIT_DONE: on the first cycle with tx_busy=0, pulse req_done[owner], clear active, go to IDLE. No timeout here; frame length is fixed by uart_tx.
- Back-to-back: the next grant cannot occur before the cycle after req_done. Transmit is never asserted while tx_busy=1 or active=1.
- Fairness: with all requests held high, grants cycle 0,1,2,3,0,…; no requester waits more than NUM_REQ-1 frames.
- Ownership: req/req_data changes by non-owners during a frame are ignored; tx_data is held until the next grant. Dropping req before ack withdraws the request with no side effects.
- Simultaneous events:
  - req_done and a new req in the same cycle: the new req is arbitrated in the following IDLE cycle.
  - start_err and req_done are mutually exclusive by construction.
- Reset mid-frame: immediate return to IDLE with all outputs 0. The in-flight frame is abandoned with no req_done. uart_tx is reset by the same reset net.

Decomposition:
- uart_pkg, shared with uart_tx: DATA_WIDTH default, the sched_state_t enum (IDLE, ISSUE, WAIT_START, WAIT_DONE), and the FRAME_WIDTH = DATA_WIDTH+3 constant for benches.
- One sub-module, rr_arbiter:
  - combinational priority pick from req and pointer, producing a one-hot grant and index;
  - the pointer register lives in the parent FSM.

Test Plan:
- Single request: req=4'b0100, req_data[2]=8'hA5. Expected: ack[2] one cycle after req, one transmit pulse, tx_data=8'hA5 for the whole frame, then done[2] when busy falls (~11*868 cycles at 100 MHz/115200).
- Round-robin: all req high with bytes 8'h10, 8'h21, 8'h32, 8'h43. Expected: serial capture 10, 21, 32, 43, 10, and exactly one transmit per frame.
- Contention after release: req0 held high while req1 asserts mid-frame of 0. Expected next grant goes to 1, then 0.
- Start timeout: tx_busy stub tied 0, req[3]=1. Expected: start_err pulse 16 cycles after ISSUE, no done[3], active=0, and the next grant favours requester 0.
- Reset mid-frame: assert reset during WAIT_DONE. Expected: outputs go 0 asynchronously, no done pulse; after release, a pending req1 is granted within 2 cycles.
- Withdrawal: req2 pulses high for 0 cycles relative to IDLE sampling (dropped before the edge). Expected: no ack, no transmit, tx_data unchanged.
